// File: rtl/lcd_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ram_arbiter
//  Purpose  : Arbitrates two character writers (A, B) onto a single LCD RAM
//             write port and runs a full-RAM fill on demand or after reset.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_ram_arbiter #(
  parameter logic [7:0] FILL_CHAR  = 8'h20,
  parameter bit         CLR_ON_RST = 1'b1
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iCLR_REQ,
  input  logic       iA_REQ,
  input  logic [4:0] iA_ADDR,
  input  logic [7:0] iA_DATA,
  output logic       oA_ACK,
  input  logic       iB_REQ,
  input  logic [4:0] iB_ADDR,
  input  logic [7:0] iB_DATA,
  output logic       oB_ACK,
  output logic [4:0] oWADDR,
  output logic [7:0] oDIN,
  output logic       oWE,
  output logic       oBUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [4:0] C_LAST_ADDR = 5'd31;

  state_t     r_state;
  logic       r_clr_pend;
  logic       r_last_b;     // 1 when B received the most recent grant
  logic [4:0] r_waddr;
  logic [7:0] r_din;
  logic       r_we;
  logic       r_a_ack;
  logic       r_b_ack;
  logic       r_busy;

  logic       w_grant_a;
  logic       w_grant_b;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  assign w_grant_a = iA_REQ && (!iB_REQ || r_last_b);
  assign w_grant_b = iB_REQ && (!iA_REQ || !r_last_b);

  // Arbitration FSM with registered RAM-port, ack and busy outputs.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= S_IDLE;
      r_clr_pend <= CLR_ON_RST;
      r_last_b   <= 1'b1;
      r_waddr    <= 5'd0;
      r_din      <= 8'd0;
      r_we       <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_we    <= 1'b0;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_busy  <= 1'b0;
          if (r_clr_pend) begin
            r_state <= S_CLEAR;
            r_waddr <= 5'd0;
            r_din   <= FILL_CHAR;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_grant_a) begin
            r_state  <= S_WRITE;
            r_waddr  <= iA_ADDR;
            r_din    <= iA_DATA;
            r_we     <= 1'b1;
            r_a_ack  <= 1'b1;
            r_last_b <= 1'b0;
          end else if (w_grant_b) begin
            r_state  <= S_WRITE;
            r_waddr  <= iB_ADDR;
            r_din    <= iB_DATA;
            r_we     <= 1'b1;
            r_b_ack  <= 1'b1;
            r_last_b <= 1'b1;
          end
        end
        S_WRITE: begin
          // Single-cycle write; requester drops REQ on this edge.
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
        end
        S_CLEAR: begin
          // Stop after address 31 rather than letting the counter wrap.
          if (r_waddr == C_LAST_ADDR) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_waddr <= r_waddr + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // A new clear request outside CLEAR always lands, even on the edge
      // that consumes the previous one.
      if (iCLR_REQ && (r_state != S_CLEAR)) begin
        r_clr_pend <= 1'b1;
      end else if ((r_state == S_IDLE) && r_clr_pend) begin
        r_clr_pend <= 1'b0;
      end
    end
  end

  assign oWADDR = r_waddr;
  assign oDIN   = r_din;
  assign oWE    = r_we;
  assign oA_ACK = r_a_ack;
  assign oB_ACK = r_b_ack;
  assign oBUSY  = r_busy;

endmodule
`default_nettype wire
